// File: rtl/nv_nvdla_cdma_wt_rsp_track.sv
// CDMA weight-response tracker: pops request descriptors, accepts the matching DMA
// beats and writes them into the circular CBUF weight region.
//
// state | meaning
// IDLE  | waiting for a descriptor; layer_start (or pending one) applied here
// RECV  | accepting beats for the current descriptor, beat_cnt beats left minus one
module nv_nvdla_cdma_wt_rsp_track #(
   parameter int DW = 512,
   parameter int AW = 12
) (
   input  logic          nvdla_core_clk,
   input  logic          nvdla_core_rstn,
   input  logic          fifo_rd_req,
   output logic          fifo_rd_ready,
   input  logic [5:0]    fifo_rd_data,
   input  logic          dma_rsp_valid,
   output logic          dma_rsp_ready,
   input  logic [DW-1:0] dma_rsp_data,
   input  logic          layer_start,
   input  logic [AW-1:0] cfg_base,
   input  logic [AW-1:0] cfg_depth,
   output logic          cbuf_wr_en,
   output logic [AW-1:0] cbuf_wr_addr,
   output logic [DW-1:0] cbuf_wr_data,
   output logic          kernel_done,
   output logic [15:0]   wt_entry_cnt,
   output logic          busy
);

   typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

   state_t        r_state;
   logic [4:0]    r_beat_cnt;
   logic          r_last_k;
   logic          r_wr_en;
   logic [AW-1:0] r_wr_addr;
   logic [DW-1:0] r_wr_data;
   logic          r_kernel_done;

   logic [AW-1:0] r_base;
   logic [AW-1:0] r_depth;
   logic [AW-1:0] r_offset;
   logic          r_pending;
   logic [15:0]   r_entry_cnt;

   logic          w_accept;
   logic          w_final;
   logic          w_pop;
   logic          w_apply;
   logic [AW-1:0] w_offset_nxt;

   assign w_accept = (r_state == RECV) & dma_rsp_valid;
   assign w_final  = w_accept & (r_beat_cnt == 5'd0);
   assign w_pop    = fifo_rd_req & ((r_state == IDLE) | w_final);
   assign w_apply  = (r_state == IDLE) & (layer_start | r_pending);

   // depth 0 makes depth-1 all ones, so the compare and the natural wrap agree at 2^AW
   assign w_offset_nxt = (r_offset == r_depth - AW'(1)) ? '0 : r_offset + AW'(1);

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         r_state       <= IDLE;
         r_beat_cnt    <= '0;
         r_last_k      <= 1'b0;
         r_wr_en       <= 1'b0;
         r_wr_addr     <= '0;
         r_wr_data     <= '0;
         r_kernel_done <= 1'b0;
      end else begin
         r_wr_en       <= w_accept;
         r_kernel_done <= w_final & r_last_k;
         if (w_accept) begin
            r_wr_addr <= r_base + r_offset;
            r_wr_data <= dma_rsp_data;
         end
         case (r_state)
            IDLE: begin
               if (w_pop) begin
                  r_state    <= RECV;
                  r_beat_cnt <= fifo_rd_data[4:0];
                  r_last_k   <= fifo_rd_data[5];
               end
            end
            RECV: begin
               if (w_accept) begin
                  if (r_beat_cnt == 5'd0) begin
                     if (fifo_rd_req) begin
                        r_beat_cnt <= fifo_rd_data[4:0];
                        r_last_k   <= fifo_rd_data[5];
                     end else begin
                        r_state <= IDLE;
                     end
                  end else begin
                     r_beat_cnt <= r_beat_cnt - 5'd1;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         r_base      <= '0;
         r_depth     <= '0;
         r_offset    <= '0;
         r_pending   <= 1'b0;
         r_entry_cnt <= '0;
      end else if (w_apply) begin
         r_base      <= cfg_base;
         r_depth     <= cfg_depth;
         r_offset    <= '0;
         r_pending   <= 1'b0;
         r_entry_cnt <= '0;
      end else begin
         if (w_accept)
            r_offset <= w_offset_nxt;
         if (r_wr_en)
            r_entry_cnt <= r_entry_cnt + 16'd1;
         // only reachable in RECV: an IDLE layer_start is applied instead
         if (layer_start)
            r_pending <= 1'b1;
      end
   end

   assign fifo_rd_ready = w_pop;
   assign dma_rsp_ready = (r_state == RECV);
   assign cbuf_wr_en    = r_wr_en;
   assign cbuf_wr_addr  = r_wr_addr;
   assign cbuf_wr_data  = r_wr_data;
   assign kernel_done   = r_kernel_done;
   assign wt_entry_cnt  = r_entry_cnt;
   assign busy          = (r_state == RECV) | r_pending;

endmodule
